// File: rtl/bitty_pkg.sv
// bitty_pkg: shared fetch FSM states, instruction field positions and default watchdog limit.
package bitty_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_STEP_S,
        S_STEP_C,
        S_WAIT_DONE,
        S_HALTED,
        S_ERROR
    } fetch_state_t;
    localparam int RX_MSB      = 15;
    localparam int RY_MSB      = 12;
    localparam int SEL_LSB     = 2;
    localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/bitty_fetch_if.sv
// bitty_fetch_if: program-load bus plus control-unit handshake between host and fetch unit.
interface bitty_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] end_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done;
    logic [DATA_W-1:0] instruction;
    logic              en_i;
    logic              en_s;
    logic              en_c;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    modport master (
        output start, end_addr, wr_en, wr_addr, wr_data, done,
        input  instruction, en_i, en_s, en_c, pc, busy, halted, error
    );
    modport slave (
        input  start, end_addr, wr_en, wr_addr, wr_data, done,
        output instruction, en_i, en_s, en_c, pc, busy, halted, error
    );
endinterface

// File: rtl/bitty_imem.sv
// bitty_imem: DEPTH x DATA_W instruction memory, single write port, registered read.
module bitty_imem #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_wr_en && 32'(i_wr_addr) < DEPTH)
            r_mem[i_wr_addr] <= i_wr_data;
    // The read register is the instruction register, so it alone is reset.
    always_ff @(posedge clk or posedge reset)
        if (reset)
            o_rd_data <= '0;
        else if (i_rd_en)
            o_rd_data <= 32'(i_rd_addr) < DEPTH ? r_mem[i_rd_addr] : '0;
endmodule

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: sequences instructions into the bitty control unit with a done watchdog.
// Define BITTY_FETCH_LOOP_EN to restart at pc 0 after the last instruction instead of halting.
module bitty_fetch_unit import bitty_pkg::*; #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic          clk,
    input logic          reset,
    bitty_fetch_if.slave fetch
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, r_end, w_end_nxt;
    logic [WD_W-1:0]   r_wdog, w_wdog_nxt;
    logic [DATA_W-1:0] w_instr;
    logic              w_busy, w_at_end;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_end   <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_end   <= w_end_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    assign w_at_end = r_pc == r_end;
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_end_nxt   = r_end;
        w_wdog_nxt  = r_wdog;
        case (r_state)
            S_IDLE, S_HALTED:
                if (fetch.start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = '0;
                    w_end_nxt   = fetch.end_addr;
                end
            S_FETCH:  w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_STEP_S;
            S_STEP_S: w_state_nxt = S_STEP_C;
            S_STEP_C: begin
                w_state_nxt = S_WAIT_DONE;
                w_wdog_nxt  = '0;
            end
            S_WAIT_DONE: begin
                w_wdog_nxt = r_wdog + 1'b1;
                // done wins over a watchdog expiring in the same cycle
                if (fetch.done) begin
`ifdef BITTY_FETCH_LOOP_EN
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = w_at_end ? '0 : r_pc + 1'b1;
`else
                    w_state_nxt = w_at_end ? S_HALTED : S_FETCH;
                    w_pc_nxt    = w_at_end ? r_pc : r_pc + 1'b1;
`endif
                end else if (r_wdog == WD_W'(TIMEOUT - 1))
                    w_state_nxt = S_ERROR;
            end
            default: ;
        endcase
    end
    assign w_busy = !(r_state inside {S_IDLE, S_HALTED, S_ERROR});
    bitty_imem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) u_imem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (fetch.wr_en && !w_busy),
        .i_wr_addr (fetch.wr_addr),
        .i_wr_data (fetch.wr_data),
        .i_rd_en   (r_state == S_FETCH),
        .i_rd_addr (r_pc),
        .o_rd_data (w_instr)
    );
    assign fetch.instruction = w_instr;
    assign fetch.en_i        = r_state == S_ISSUE;
    assign fetch.en_s        = r_state == S_STEP_S;
    assign fetch.en_c        = r_state == S_STEP_C;
    assign fetch.pc          = r_pc;
    assign fetch.busy        = w_busy;
    assign fetch.halted      = r_state == S_HALTED;
    assign fetch.error       = r_state == S_ERROR;
endmodule

// File: tb/tb_bitty_fetch_unit.sv
// tb_bitty_fetch_unit: scoreboard bench; expected {pc,instruction} queued per issue, popped on en_i.
module tb_bitty_fetch_unit;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;
    bitty_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();
    bitty_fetch_unit dut (.clk(clk), .reset(reset), .fetch(bus));
    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    logic cu_hang = 0;
    logic d1 = 0;
    logic d2 = 0;
    logic p_en_i = 0;
    logic p_en_s = 0;
    logic [23:0] exp_q[$];
    // control-unit stub: done in the second WAIT_DONE cycle unless hung
    assign bus.done = d2;
    always @(posedge clk) begin
        if (d2) n_done++;
        d1 <= bus.en_c && !cu_hang;
        d2 <= d1;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask
    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 0;
    endtask
    task automatic go(input logic [7:0] ea, input logic we, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.start = 1; bus.end_addr = ea; bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.start = 0; bus.wr_en = 0;
    endtask
    task automatic wait_halt(output int n);
        n = 0;
        while (!bus.halted && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask
    task automatic mon_step();
        logic [23:0] e;
        @(negedge clk);
        if (reset) begin
            p_en_i = 0; p_en_s = 0;
        end else begin
            chk("enables_onehot", 32'($onehot0({bus.en_i, bus.en_s, bus.en_c})), 1);
            if (bus.en_s) chk("en_s_follows_en_i", 32'(p_en_i), 1);
            if (bus.en_c) chk("en_c_follows_en_s", 32'(p_en_s), 1);
            if (bus.en_i) begin
                if (exp_q.size() == 0) chk("unexpected_issue_pc", 32'(bus.pc), 32'hffff_ffff);
                else begin
                    e = exp_q.pop_front();
                    chk("issue_pc", 32'(bus.pc), 32'(e[23:16]));
                    chk("issue_instr", 32'(bus.instruction), 32'(e[15:0]));
                end
            end
            p_en_i = bus.en_i; p_en_s = bus.en_s;
        end
    endtask
    initial begin
        int n, d0;
        logic seen;
        bus.start = 0; bus.end_addr = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        fork
            forever mon_step();
        join_none
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({bus.pc, bus.instruction, bus.en_i, bus.en_s, bus.en_c,
                                  bus.busy, bus.halted, bus.error}), 0);
        reset = 0;
        wr(0, 16'h2404); wr(1, 16'h4808); wr(2, 16'h0000);
`ifdef BITTY_FETCH_LOOP_EN
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({8'd0, 16'h2404});
            exp_q.push_back({8'd1, 16'h4808});
        end
        go(1, 0, 0, 0);
        n = 0; seen = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            seen = seen | bus.halted;
            n++;
        end
        #1 reset = 1;
        chk("loop_drained", exp_q.size(), 0);
        chk("loop_never_halted", 32'(seen), 0);
        #1 chk("loop_reset_busy", 32'(bus.busy), 0);
`else
        d0 = n_done;
        exp_q.push_back({8'd0, 16'h2404}); exp_q.push_back({8'd1, 16'h4808}); exp_q.push_back({8'd2, 16'h0000});
        go(2, 0, 0, 0);
        wait_halt(n);
        chk("halt_cycles", n, 18);
        chk("halt_pc", 32'(bus.pc), 2);
        chk("done_pulses", n_done - d0, 3);
        chk("halted_not_busy", 32'(bus.busy), 0);
        repeat (5) @(negedge clk);
        chk("halt_sticky", 32'({bus.halted, bus.pc}), 32'h102);
        exp_q.push_back({8'd0, 16'h2404}); exp_q.push_back({8'd1, 16'h4808}); exp_q.push_back({8'd2, 16'h0000});
        go(2, 0, 0, 0);
        repeat (2) @(negedge clk);
        wr(1, 16'hbeef);
        wait_halt(n);
        chk("busy_write_run_halts", 32'(bus.halted), 1);
        wr(1, 16'hbeef);
        exp_q.push_back({8'd0, 16'h1234}); exp_q.push_back({8'd1, 16'hbeef}); exp_q.push_back({8'd2, 16'h0000});
        go(2, 1, 0, 16'h1234);
        wait_halt(n);
        chk("write_start_run_cycles", n, 18);
        cu_hang = 1;
        exp_q.push_back({8'd0, 16'h1234});
        go(0, 0, 0, 0);
        n = 0;
        while (!bus.error && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("wdog_cycles", n, 19);
        chk("error_quiet", 32'({bus.busy, bus.halted, bus.en_i, bus.en_s, bus.en_c}), 0);
        go(0, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("error_sticky", 32'({bus.error, bus.busy}), 32'h2);
        #1 reset = 1;
        #1 chk("reset_clears_error", 32'(bus.error), 0);
        @(negedge clk) reset = 0;
        cu_hang = 0;
        exp_q.push_back({8'd0, 16'h1234});
        go(2, 0, 0, 0);
        n = 0;
        while (!bus.en_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_step_s", 32'(bus.en_s), 1);
        #1 reset = 1;
        #1 chk("async_reset_outputs", 32'({bus.pc, bus.instruction, bus.en_i, bus.en_s, bus.en_c,
                                          bus.busy, bus.halted, bus.error}), 0);
        @(negedge clk) reset = 0;
        exp_q.push_back({8'd0, 16'h1234}); exp_q.push_back({8'd1, 16'hbeef}); exp_q.push_back({8'd2, 16'h0000});
        go(2, 0, 0, 0);
        wait_halt(n);
        chk("restart_cycles", n, 18);
        chk("restart_pc", 32'(bus.pc), 2);
`endif
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
